// File: rtl/posit_to_fir_pipe.sv
// posit_to_fir_pipe: two-stage valid/ready decoder from an N-bit posit to FIR {sign, te, frac_full}.
// Define PTF_SKID_BUF_EN to add a one-entry input skid buffer with a registered in_ready.
module posit_to_fir_pipe #(
  parameter  int N              = 16,
  parameter  int ES             = 1,
  localparam int TE_SIZE        = ES + $clog2(N) + 1,
  localparam int FRAC_FULL_SIZE = N - 3 - ES,
  localparam int FIR_TOTAL_SIZE = 1 + TE_SIZE + FRAC_FULL_SIZE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0]              in_posit,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FIR_TOTAL_SIZE-1:0] out_fir,
  output logic                      out_is_zero,
  output logic                      out_is_nar
);

  localparam int RW = N - 1;
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  function automatic int regime_len(input logic [RW-1:0] r);
    int  m;
    logic run;
    m   = 0;
    run = 1'b1;
    for (int i = RW - 1; i >= 0; i--) begin
      if (run && (r[i] == r[RW-1])) m++;
      else run = 1'b0;
    end
    return m;
  endfunction

  // Bits shifted past the LSB read as zero, so short tails zero-pad exp and frac.
  function automatic logic [TE_SIZE+FRAC_FULL_SIZE-1:0] decode(input logic [RW-1:0] r);
    int m, k, ex;
    logic [RW-1:0] sh;
    logic signed [TE_SIZE-1:0] te;
    m  = regime_len(r);
    k  = r[RW-1] ? m - 1 : -m;
    sh = r << (m + 1);
    ex = int'(sh >> (RW - ES));
    te = TE_SIZE'(k * (1 << ES) + ex);
    return {te, sh[RW-1-ES -: FRAC_FULL_SIZE]};
  endfunction

  logic                      s1_load, s2_load;
  logic                      src_v;
  logic [N-1:0]              src_posit;
  logic [RW-1:0]             abs_d;
  logic                      vld_p1_q, sign_p1_q, zero_p1_q, nar_p1_q;
  logic [RW-1:0]             abs_p1_q;
  logic                      vld_p2_q, zero_p2_q, nar_p2_q;
  logic [FIR_TOTAL_SIZE-1:0] fir_p2_q, fir_p2_d;

  assign s2_load = !vld_p2_q || out_ready;
  assign s1_load = !vld_p1_q || s2_load;

`ifdef PTF_SKID_BUF_EN
  logic          skid_v_q, skid_v_d;
  logic [N-1:0]  skid_q;

  assign in_ready  = rst_n && !skid_v_q;
  assign src_v     = skid_v_q || (in_valid && in_ready);
  assign src_posit = skid_v_q ? skid_q : in_posit;

  always_comb begin
    skid_v_d = skid_v_q;
    if (skid_v_q && s1_load) skid_v_d = 1'b0;
    else if (!skid_v_q && in_valid && in_ready && !s1_load) skid_v_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) skid_v_q <= 1'b0;
    else        skid_v_q <= skid_v_d;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready && !skid_v_q) skid_q <= in_posit;
  end
`else
  assign in_ready  = rst_n && s1_load;
  assign src_v     = in_valid && in_ready;
  assign src_posit = in_posit;
`endif

  assign abs_d = src_posit[N-1] ? RW'(-src_posit) : src_posit[RW-1:0];

  // Stage 1: sign, magnitude and special-value flags
  always_ff @(posedge clk) begin
    if (!rst_n)       vld_p1_q <= 1'b0;
    else if (s1_load) vld_p1_q <= src_v;
  end

  always_ff @(posedge clk) begin
    if (s1_load && src_v) begin
      sign_p1_q <= src_posit[N-1];
      abs_p1_q  <= abs_d;
      zero_p1_q <= (src_posit == '0);
      nar_p1_q  <= (src_posit == NAR);
    end
  end

  // Stage 2: regime/exponent/fraction extraction
  always_comb begin
    fir_p2_d = '0;
    if (!zero_p1_q && !nar_p1_q) fir_p2_d = {sign_p1_q, decode(abs_p1_q)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2_q  <= 1'b0;
      fir_p2_q  <= '0;
      zero_p2_q <= 1'b0;
      nar_p2_q  <= 1'b0;
    end else if (s2_load) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        fir_p2_q  <= fir_p2_d;
        zero_p2_q <= zero_p1_q;
        nar_p2_q  <= nar_p1_q;
      end
    end
  end

  assign out_valid   = vld_p2_q;
  assign out_fir     = fir_p2_q;
  assign out_is_zero = zero_p2_q;
  assign out_is_nar  = nar_p2_q;

endmodule

// File: tb/tb_posit_to_fir_pipe.sv
// Bench for posit_to_fir_pipe (N=16, ES=1): directed steps plus scoreboard of accepted posits.
`timescale 1ns/1ps
module tb_posit_to_fir_pipe;
  localparam int N  = 16;
  localparam int FW = 19;
`ifdef PTF_SKID_BUF_EN
  localparam int EXP_ACC = 3;
`else
  localparam int EXP_ACC = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_posit = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [FW-1:0] out_fir;
  logic          out_is_zero, out_is_nar;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed { logic [15:0] p; logic [20:0] e; } sb_t;
  sb_t sb[$];

  logic        stall_prev = 1'b0;
  logic [20:0] held = '0;

  logic [15:0] dir_p [5] = '{16'hC000, 16'h0001, 16'h7FFF, 16'h0000, 16'h8000};
  logic [20:0] dir_e [5] = '{{2'b00, 19'h40000}, {2'b00, 19'h24000}, {2'b00, 19'h1C000},
                             {2'b10, 19'h00000}, {2'b01, 19'h00000}};
  logic [15:0] st_p  [4] = '{16'h4000, 16'h5000, 16'h4800, 16'hC000};

  always #5 clk = ~clk;

  posit_to_fir_pipe #(.N(16), .ES(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_posit(in_posit),
    .out_valid(out_valid), .out_ready(out_ready), .out_fir(out_fir),
    .out_is_zero(out_is_zero), .out_is_nar(out_is_nar));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decode, bit by bit: returns {is_zero, is_nar, fir}.
  function automatic logic [20:0] model(input logic [15:0] p);
    logic [15:0] a;
    logic r;
    logic [11:0] fr;
    logic [5:0] te6;
    int i, m, k, e, te;
    if (p == 16'h0000) return {2'b10, 19'h0};
    if (p == 16'h8000) return {2'b01, 19'h0};
    a = p[15] ? -p : p;
    r = a[14];
    i = 14;
    m = 0;
    while (i >= 0) begin
      if (a[i] != r) break;
      m++;
      i--;
    end
    k = r ? m - 1 : -m;
    i--;
    e = 0;
    if (i >= 0) e = int'(a[i]);
    i--;
    fr = '0;
    for (int j = 11; j >= 0; j--) begin
      if (i >= 0) fr[j] = a[i];
      i--;
    end
    te  = 2 * k + e;
    te6 = te[5:0];
    return {2'b00, p[15], te6, fr};
  endfunction

  // Re-encodes a FIR word into a posit (exact, no rounding needed for decoded values).
  function automatic logic [15:0] encode(input logic [18:0] f, input logic z, input logic nr);
    logic [63:0] b;
    logic signed [5:0] te;
    logic [14:0] body;
    logic [15:0] p;
    int len, k, e;
    if (z)  return 16'h0000;
    if (nr) return 16'h8000;
    te  = f[17:12];
    k   = int'(te) >>> 1;
    e   = int'(te) & 1;
    b   = '0;
    len = 0;
    if (k >= 0) begin
      for (int i = 0; i <= k; i++) begin b = {b[62:0], 1'b1}; len++; end
      b = {b[62:0], 1'b0}; len++;
    end else begin
      for (int i = 0; i < -k; i++) begin b = {b[62:0], 1'b0}; len++; end
      b = {b[62:0], 1'b1}; len++;
    end
    b = {b[62:0], e[0]}; len++;
    for (int i = 11; i >= 0; i--) begin b = {b[62:0], f[i]}; len++; end
    body = (len >= 15) ? 15'(b >> (len - 15)) : 15'(b << (15 - len));
    p = {1'b0, body};
    if (f[18]) p = -p;
    return p;
  endfunction

  always @(negedge clk) begin
    sb_t t;
    if (!rst_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'({out_is_zero, out_is_nar, out_fir}), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          t = sb.pop_front();
          chk("fir", 32'(out_fir), 32'(t.e[18:0]));
          chk("flags", 32'({out_is_zero, out_is_nar}), 32'(t.e[20:19]));
          chk("roundtrip", 32'(encode(out_fir, out_is_zero, out_is_nar)), 32'(t.p));
        end
      end
      stall_prev <= out_valid && !out_ready;
      held <= {out_is_zero, out_is_nar, out_fir};
      if (in_valid && in_ready) sb.push_back('{p: in_posit, e: model(in_posit)});
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] hold;
    int acc;
    hold = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_fir", 32'(out_fir), 32'd0);
    chk("rst_flags", 32'({out_is_zero, out_is_nar}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    in_valid = 1'b1; in_posit = 16'h4000; step();
    in_posit = 16'h5000; step();
    chk("b2b0_valid", 32'(out_valid), 32'd1);
    chk("b2b0_fir", 32'(out_fir), 32'h00000);
    in_posit = 16'h4800; step();
    chk("b2b1_valid", 32'(out_valid), 32'd1);
    chk("b2b1_fir", 32'(out_fir), 32'h01000);
    in_valid = 1'b0; step();
    chk("b2b2_valid", 32'(out_valid), 32'd1);
    chk("b2b2_fir", 32'(out_fir), 32'h00800);
    step();
    chk("b2b_end_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_posit = dir_p[i]; step();
      in_valid = 1'b0; step();
      chk("dir_valid", 32'(out_valid), 32'd1);
      chk("dir_fir", 32'(out_fir), 32'(dir_e[i][18:0]));
      chk("dir_flags", 32'({out_is_zero, out_is_nar}), 32'(dir_e[i][20:19]));
      step();
    end

    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (acc < 4);
      in_posit = st_p[(acc < 4) ? acc : 0];
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
      if (c == 3) hold = out_fir;
      if (c > 3) chk("stall_stable", 32'(out_fir), 32'(hold));
    end
    in_valid = 1'b0;
    #1;
    chk("stall_accepted", 32'(acc), 32'(EXP_ACC));
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    repeat (6) step();
    chk("stall_drained", 32'(sb.size()), 32'd0);
    chk("stall_end_valid", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    in_valid = 1'b1; in_posit = 16'h5000; step();
    in_posit = 16'h4800; step();
    in_valid = 1'b0; step();
    rst_n = 1'b0; step();
    sb.delete();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_posit = 16'h4000; step();
    in_valid = 1'b0; step();
    chk("midrst_new_valid", 32'(out_valid), 32'd1);
    chk("midrst_new_fir", 32'(out_fir), 32'h00000);
    step();
    chk("midrst_end_valid", 32'(out_valid), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_posit  = 16'($urandom);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();
    chk("rand_drained", 32'(sb.size()), 32'd0);

    for (int v = 0; v < 65536; v++) begin
      in_valid = 1'b1;
      in_posit = 16'(v);
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();
    chk("sweep_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
